mem_arbiter_rr: RTL
===================

Name: mem_arbiter_rr

Overview:
- Parametrised successor to the single-client line fetcher that sits between the core's memory clients (I-fetch, D-cache fill/writeback, ...) and the shared Sysbus.
- Accepts line-sized read and write requests from NUM_CLIENTS clients and grants one at a time, round-robin.
- Drives the Sysbus request/response handshake and assembles read beats into a full line.
- Returns per-client completion with data; one transaction is outstanding on the bus at a time.

Parameters:
NUM_CLIENTS, 2, number of requesting clients (>=1)
LINE_BYTES, 64, bytes per transaction (power of 2, multiple of BEAT_BYTES)
BEAT_BYTES, 8, bytes per bus beat (bus data width / 8)
ADDR_WIDTH, 64, address width
TAG_WIDTH, 13, Sysbus tag width

Ports:
clk  in  1  bus clock
reset  in  1  synchronous active-high reset
cl_req  in  NUM_CLIENTS  per-client request valid; held until cl_done
cl_write  in  NUM_CLIENTS  per-client 1=write line, 0=read line
cl_addr  in  NUM_CLIENTS*ADDR_WIDTH  per-client byte address
cl_wdata  in  NUM_CLIENTS*LINE_BYTES*8  per-client write line
cl_done  out  NUM_CLIENTS  one-cycle completion pulse, one-hot
cl_rdata  out  LINE_BYTES*8  assembled read line, valid while cl_done high and held after
bus_reqcyc  out  1  Sysbus request valid
bus_reqack  in  1  Sysbus request accepted
bus_req  out  BEAT_BYTES*8  address beat, then write data beats
bus_reqtag  out  TAG_WIDTH  {READ/WRITE, MEMORY, 8'b0}
bus_respcyc  in  1  response beat valid
bus_respack  out  1  equals bus_respcyc (always accepts)
bus_resp  in  BEAT_BYTES*8  response data beat

Behaviour:
- Reset values: state IDLE, rr_ptr=0, bus_reqcyc=0, bus_req=0, bus_reqtag=0, cl_done=0, cl_rdata=0, beat counter=0. Reset mid-transaction abandons it with no cl_done.
- BEATS=LINE_BYTES/BEAT_BYTES. Beat counter is clog2(BEATS)+1 bits wide.
- Arbitration is evaluated in IDLE only.
  - Grant the first asserted cl_req starting at rr_ptr, wrapping modulo NUM_CLIENTS.
  - Latch the winner's id, write flag, and address aligned down to LINE_BYTES; latch wdata for writes.
  - Set rr_ptr = winner+1 (mod NUM_CLIENTS) at grant.
  - Grant to request-address cycle is 1 cycle.
- States:
  - IDLE -> ADDR on grant.
  - ADDR: bus_reqcyc=1, bus_req=aligned addr, tag per op. Hold until bus_reqack. On ack, go to WDATA (write) or WAIT (read).
  - WDATA: bus_reqcyc=1, bus_req=beat k of wdata, beat 0 = lowest bytes. Advance k on each bus_reqack. After beat BEATS-1 is acked, go to WAIT.
  - WAIT: bus_reqcyc=0. The first bus_respcyc goes to RESP and stores beat 0.
    - Reads: beat i lands in cl_rdata byte offset i*BEAT_BYTES.
    - Writes: expect exactly one response beat (ack), data ignored, then go to DONE.
  - RESP (read): store each respcyc beat. When beat BEATS-1 is stored, go to DONE. Cycles with respcyc=0 inside the burst are tolerated (no timeout).
  - DONE: pulse cl_done[winner] for 1 cycle, then IDLE. A new grant occurs at the earliest in the cycle after DONE.
- bus_respcyc in IDLE/ADDR/WDATA is a protocol error: assertion fatal in simulation, ignored in synthesis.
- Extra beats beyond BEATS are ignored, and an assertion fires.
- A client deasserting cl_req after grant does not cancel the transaction; cl_done still pulses.
- cl_rdata for a write completion is unchanged from its previous value.
- NUM_CLIENTS=1 degenerates to a fixed grant; rr_ptr stays 0.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ADDR, WDATA, WAIT, RESP, DONE), READ/WRITE and MEMORY tag constants, localparam helpers BEATS and BEAT_IDX_W.
- Sub-module rr_arbiter (NUM_CLIENTS): request vector, pointer, and enable in; one-hot grant, binary index, and valid out. Purely combinational plus the pointer register.

Test Plan:
- Single read: client0 requests addr 0x1038. Expect bus_req=0x1000 with READ tag. Respond with beats 0x11..0x88 (8 beats). Expect cl_rdata beat i = value i, cl_done=01 for exactly 1 cycle.
- Single write: client1 writes addr 0x2000 with line bytes 0x00..0x3F. Expect address beat, then 8 data beats with the first = 0x0706050403020100 and each advancing only on reqack (reqack stalled 2 cycles between beats). Send one response beat; expect cl_done=10.
- Round robin: both clients request continuously for 4 transactions. Expect grant order 0,1,0,1 and rr_ptr wrap at NUM_CLIENTS=3 with clients 0 and 2 active: 0,2,0,2.
- Gapped response: insert respcyc=0 bubbles between beats 3 and 4. Expect correct line assembly and done only after beat 7.
- Reset mid-read after 3 beats. Expect all outputs at reset values next cycle, no cl_done, and a clean new read completing afterwards.
- LINE_BYTES=32, BEAT_BYTES=8 build: expect 4-beat read completion and 32-byte alignment (0x1038 -> 0x1020).

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the round-robin Sysbus line arbiter.
// Tag layout is {op, memory space, 8'b0}.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWdata,
    StWait,
    StResp,
    StDone
  } arb_state_e;

  localparam logic       TagOpRead  = 1'b0;
  localparam logic       TagOpWrite = 1'b1;
  localparam logic [3:0] TagMemory  = 4'h1;

  function automatic int unsigned beats(input int unsigned line_bytes,
                                        input int unsigned beat_bytes);
    return line_bytes / beat_bytes;
  endfunction

  function automatic int unsigned beat_idx_w(input int unsigned line_bytes,
                                             input int unsigned beat_bytes);
    return $clog2(beats(line_bytes, beat_bytes)) + 1;
  endfunction

  function automatic logic [12:0] make_tag(input logic op);
    return {op, TagMemory, 8'h00};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after the pointer, wrapping.
// The pointer moves past the winner only when a grant is taken (en).
module rr_arbiter #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned IdW         = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic                   en,
  output logic [NUM_CLIENTS-1:0] gnt,
  output logic [IdW-1:0]         idx,
  output logic                   valid
);

  logic [IdW-1:0] ptr_q;
  int unsigned    cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      cand = (32'(ptr_q) + k) % NUM_CLIENTS;
      if (!valid && |(req & (NUM_CLIENTS'(1) << cand))) begin
        valid = 1'b1;
        idx   = IdW'(cand);
        gnt   = NUM_CLIENTS'(1) << cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (en && valid) begin
      if (idx == IdW'(NUM_CLIENTS - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Multi-client line fetcher: round-robin grant, one Sysbus transaction at a time,
// read beats assembled into a full line, one-hot completion pulse per client.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned LINE_BYTES  = 64,
  parameter int unsigned BEAT_BYTES  = 8,
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned TAG_WIDTH   = 13
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CLIENTS-1:0]             cl_req,
  input  logic [NUM_CLIENTS-1:0]             cl_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]  cl_addr,
  input  logic [NUM_CLIENTS*LINE_BYTES*8-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]             cl_done,
  output logic [LINE_BYTES*8-1:0]            cl_rdata,
  output logic                               bus_reqcyc,
  input  logic                               bus_reqack,
  output logic [BEAT_BYTES*8-1:0]            bus_req,
  output logic [TAG_WIDTH-1:0]               bus_reqtag,
  input  logic                               bus_respcyc,
  output logic                               bus_respack,
  input  logic [BEAT_BYTES*8-1:0]            bus_resp
);

  localparam int unsigned Beats    = beats(LINE_BYTES, BEAT_BYTES);
  localparam int unsigned BeatIdxW = beat_idx_w(LINE_BYTES, BEAT_BYTES);
  localparam int unsigned LineW    = LINE_BYTES * 8;
  localparam int unsigned BeatW    = BEAT_BYTES * 8;
  localparam int unsigned IdW      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [BeatIdxW-1:0] LastBeat = BeatIdxW'(Beats - 1);

  arb_state_e             state_q;
  logic [NUM_CLIENTS-1:0] gnt_q;
  logic                   write_q;
  logic [LineW-1:0]       wdata_q;
  logic [BeatIdxW-1:0]    cnt_q;

  logic [NUM_CLIENTS-1:0] arb_gnt;
  logic [IdW-1:0]         arb_idx;
  logic                   arb_valid;
  logic                   arb_write;
  logic [ADDR_WIDTH-1:0]  arb_addr;

  assign bus_respack = bus_respcyc;

  rr_arbiter #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IdW        (IdW)
  ) u_rr_arbiter (
    .clk  (clk),
    .reset(reset),
    .req  (cl_req),
    .en   (state_q == StIdle),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .valid(arb_valid)
  );

  assign arb_write = |(cl_write & arb_gnt);
  assign arb_addr  = ADDR_WIDTH'(cl_addr >> (arb_idx * ADDR_WIDTH)) &
                     ~ADDR_WIDTH'(LINE_BYTES - 1);

  function automatic logic [LineW-1:0] put_beat(input logic [LineW-1:0]    line,
                                                input logic [BeatW-1:0]    beat,
                                                input logic [BeatIdxW-1:0] idx);
    logic [LineW-1:0] mask;
    mask = LineW'({BeatW{1'b1}}) << (idx * BeatW);
    return (line & ~mask) | (LineW'(beat) << (idx * BeatW));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      cl_done    <= '0;
      cl_rdata   <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
    end else begin
      cl_done <= '0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            gnt_q      <= arb_gnt;
            write_q    <= arb_write;
            bus_reqcyc <= 1'b1;
            bus_req    <= BeatW'(arb_addr);
            bus_reqtag <= TAG_WIDTH'(make_tag(arb_write ? TagOpWrite : TagOpRead));
            if (arb_write) begin
              wdata_q <= LineW'(cl_wdata >> (arb_idx * LineW));
            end
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (bus_reqack) begin
            cnt_q <= '0;
            if (write_q) begin
              bus_req <= BeatW'(wdata_q);
              state_q <= StWdata;
            end else begin
              bus_reqcyc <= 1'b0;
              state_q    <= StWait;
            end
          end
        end
        StWdata: begin
          // wdata_q shifts down so the next beat is always in the low bits.
          if (bus_reqack) begin
            if (cnt_q == LastBeat) begin
              bus_reqcyc <= 1'b0;
              cnt_q      <= '0;
              state_q    <= StWait;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              wdata_q <= wdata_q >> BeatW;
              bus_req <= BeatW'(wdata_q >> BeatW);
            end
          end
        end
        StWait: begin
          if (bus_respcyc) begin
            if (write_q) begin
              cl_done <= gnt_q;
              state_q <= StDone;
            end else begin
              cl_rdata <= put_beat(cl_rdata, bus_resp, cnt_q);
              cnt_q    <= cnt_q + 1'b1;
              if (LastBeat == '0) begin
                cl_done <= gnt_q;
                state_q <= StDone;
              end else begin
                state_q <= StResp;
              end
            end
          end
        end
        StResp: begin
          if (bus_respcyc) begin
            cl_rdata <= put_beat(cl_rdata, bus_resp, cnt_q);
            if (cnt_q == LastBeat) begin
              cl_done <= gnt_q;
              state_q <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  a_resp_phase: assert property (@(posedge clk) disable iff (reset)
    bus_respcyc |-> !(state_q inside {StIdle, StAddr, StWdata}))
    else $fatal(1, "response beat outside response phase");

  a_extra_beat: assert property (@(posedge clk) disable iff (reset)
    !(bus_respcyc && state_q == StDone))
    else $error("response beat beyond end of line");

endmodule
